mac_frame_gen: RTL

Ethernet test-frame transmitter that drives the byte-wide MAC TX interface of mac_rgmii (mac_tx_data/valid/sof/eof).
It is the transmit counterpart of the RX-side frame checker and produces frames with a fixed header, a 32-bit sequence number and a deterministic payload pattern.
It runs in the mac_gtx_clk domain. A run is started and counted via AXI-lite control registers in usr_logic.
The MAC adds preamble, SFD and FCS; this block emits only the header and payload bytes.

---
 rtl/mac_frame_gen_pkg.sv | 40 ++++
 rtl/mac_frame_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mac_frame_gen_pkg.sv
// Shared constants and helpers for the Ethernet test-frame transmitter.
package mac_frame_gen_pkg;

    // FSM state encoding
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] SEQ  = 3'd2;
    localparam logic [2:0] PAY  = 3'd3;
    localparam logic [2:0] IFG  = 3'd4;

    localparam int HDR_LEN = 14;
    localparam int SEQ_LEN = 4;
    localparam int PAY_MIN = 46;
    localparam int PAY_MAX = 1500;

    // Header byte at frame index idx: DST MAC, SRC MAC, EtherType, MSB first.
    function automatic logic [7:0] hdr_byte(input logic [10:0] idx,
                                            input logic [47:0] dst,
                                            input logic [47:0] src,
                                            input logic [15:0] ethtype);
        logic [111:0] hdr;
        logic [7:0]   b;
        hdr = {dst, src, ethtype};
        b   = 8'h00;
        for (int i = 0; i < HDR_LEN; i++) begin
            if (idx == 11'(i)) b = hdr[8*(HDR_LEN-1-i) +: 8];
        end
        return b;
    endfunction

    // Payload length is forced into the legal Ethernet payload range.
    function automatic logic [10:0] clamp_len(input logic [10:0] len);
        logic [10:0] r;
        if (len < 11'(PAY_MIN))      r = 11'(PAY_MIN);
        else if (len > 11'(PAY_MAX)) r = 11'(PAY_MAX);
        else                         r = len;
        return r;
    endfunction

endpackage

// File: rtl/mac_frame_gen.sv
// Ethernet test-frame generator: header, 32-bit sequence number and a
// deterministic payload onto the byte-wide MAC TX interface.
module mac_frame_gen
    import mac_frame_gen_pkg::*;
#(
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h000A_3500_0001,
    parameter logic [15:0] ETHTYPE    = 16'h88B5,
    parameter int          IFG_CYCLES = 12
) (
    input  logic        aclk,
    input  logic        areset_n,
    input  logic        start,
    input  logic [15:0] frame_count,
    input  logic [10:0] payload_len,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_valid,
    output logic        mac_tx_sof,
    output logic        mac_tx_eof,
    output logic        busy,
    output logic        done,
    output logic [31:0] frames_sent
);

    logic [2:0]  state_q, state_d;
    logic [10:0] idx_q, idx_d;      // byte index within the frame (0 = first header byte)
    logic [7:0]  ifg_q, ifg_d;      // idle cycles emitted so far in the gap
    logic [10:0] len_q, len_d;      // latched, clamped payload length
    logic [31:0] seq_q, seq_d;
    logic [31:0] sent_q, sent_d;
    logic [15:0] fc_q, fc_d;
    logic        start_q, edge_q;
    logic [7:0]  data_d;
    logic        valid_d, sof_d, eof_d, done_d;
    logic        new_frame, advance;
    logic [10:0] last_idx;

    assign last_idx = len_q + 11'(HDR_LEN - 1);

    // Byte value at frame index idx for the frame carrying sequence number seq.
    function automatic logic [7:0] frame_byte(input logic [10:0] idx, input logic [31:0] seq);
        logic [7:0] b;
        if (idx < 11'(HDR_LEN))  b = hdr_byte(idx, DST_MAC, SRC_MAC, ETHTYPE);
        else if (idx == 11'd14)  b = seq[31:24];
        else if (idx == 11'd15)  b = seq[23:16];
        else if (idx == 11'd16)  b = seq[15:8];
        else if (idx == 11'd17)  b = seq[7:0];
        else                     b = idx[7:0] - 8'd14 + seq[7:0];
        return b;
    endfunction

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ifg_d     = ifg_q;
        len_d     = len_q;
        seq_d     = seq_q;
        sent_d    = sent_q;
        fc_d      = fc_q;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        done_d    = 1'b0;
        new_frame = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_q) begin
                    sent_d    = '0;
                    seq_d     = '0;
                    fc_d      = frame_count;
                    new_frame = 1'b1;
                end
            end
            HDR, SEQ, PAY: begin
                if (idx_q == last_idx) begin
                    state_d = IFG;
                    ifg_d   = 8'd1;
                end else begin
                    advance = 1'b1;
                end
            end
            IFG: begin
                if (ifg_q != 8'(IFG_CYCLES)) begin
                    ifg_d = ifg_q + 8'd1;
                end else if (fc_q != 16'd0) begin
                    if (sent_q == {16'd0, fc_q}) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        new_frame = 1'b1;
                    end
                end else if (start) begin
                    new_frame = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (new_frame) begin
            state_d = HDR;
            idx_d   = 11'd0;
            len_d   = clamp_len(payload_len);
            valid_d = 1'b1;
            sof_d   = 1'b1;
        end

        if (advance) begin
            idx_d   = idx_q + 11'd1;
            valid_d = 1'b1;
            if (idx_d < 11'(HDR_LEN))                state_d = HDR;
            else if (idx_d < 11'(HDR_LEN + SEQ_LEN)) state_d = SEQ;
            else                                     state_d = PAY;
            eof_d = (idx_d == last_idx);
            // The frame counters advance together with the eof byte.
            if (eof_d) begin
                seq_d = seq_q + 32'd1;
                if (sent_q != 32'hFFFF_FFFF) sent_d = sent_q + 32'd1;
            end
        end

        // seq_q (not seq_d) is the number carried by the frame being emitted.
        data_d = valid_d ? frame_byte(idx_d, seq_q) : 8'h00;
    end

    // State, counters and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ifg_q        <= '0;
            len_q        <= 11'(PAY_MIN);
            seq_q        <= '0;
            sent_q       <= '0;
            fc_q         <= '0;
            start_q      <= 1'b0;
            edge_q       <= 1'b0;
            mac_tx_data  <= '0;
            mac_tx_valid <= 1'b0;
            mac_tx_sof   <= 1'b0;
            mac_tx_eof   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ifg_q        <= ifg_d;
            len_q        <= len_d;
            seq_q        <= seq_d;
            sent_q       <= sent_d;
            fc_q         <= fc_d;
            start_q      <= start;
            edge_q       <= start & ~start_q;
            mac_tx_data  <= data_d;
            mac_tx_valid <= valid_d;
            mac_tx_sof   <= sof_d;
            mac_tx_eof   <= eof_d;
            busy         <= (state_d != IDLE);
            done         <= done_d;
        end
    end

    assign frames_sent = sent_q;

endmodule
